// File: rtl/sm3_compress.sv
// SM3 compression function CF(V, B): one round per clock, 64 rounds, with the message
// expansion produced on the fly by a 16-word sliding window.
//
// state | meaning
// IDLE  | waiting for start, output_hash held
// RUN   | executing round j each edge, j = 0..63
// FINAL | fold ABCDEFGH into V, pulse done; may accept the next block

module sm3_compress #(
    parameter logic [31:0] T_LOW  = 32'h79CC4519,
    parameter logic [31:0] T_HIGH = 32'h7A879D8A
) (
    input  logic         input_clk,
    input  logic         input_rst,
    input  logic         input_start,
    input  logic [255:0] input_V,
    input  logic [511:0] input_B,
    output logic         output_busy,
    output logic         output_done,
    output logic [255:0] output_hash
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FINAL = 2'd2
    } state_t;

    state_t       state;
    state_t       state_nx;
    logic         load;
    logic         finish;
    logic [6:0]   j;
    logic [31:0]  ra, rb, rc, rd, re, rf, rg, rh;
    logic [31:0]  win [16];
    logic [255:0] v_lat;

    logic [31:0]  a12, t_j, ss1, ss2, ff_v, gg_v, tt1, tt2, w_new;

    function automatic logic [31:0] rol(input logic [31:0] x, input logic [4:0] n);
        logic [63:0] t;
        t = {x, x} << n;
        return t[63:32];
    endfunction

    function automatic logic [31:0] p0(input logic [31:0] x);
        return x ^ rol(x, 5'd9) ^ rol(x, 5'd17);
    endfunction

    function automatic logic [31:0] p1(input logic [31:0] x);
        return x ^ rol(x, 5'd15) ^ rol(x, 5'd23);
    endfunction

    function automatic logic [31:0] ff_j(input logic [31:0] x, input logic [31:0] y,
                                         input logic [31:0] z, input logic [6:0] jj);
        if (jj < 7'd16)
            return x ^ y ^ z;
        else
            return (x & y) | (x & z) | (y & z);
    endfunction

    function automatic logic [31:0] gg_j(input logic [31:0] x, input logic [31:0] y,
                                         input logic [31:0] z, input logic [6:0] jj);
        if (jj < 7'd16)
            return x ^ y ^ z;
        else
            return (x & y) | (~x & z);
    endfunction

    // round datapath; j[4:0] is exactly (j mod 32) for the constant rotation
    assign a12   = rol(ra, 5'd12);
    assign t_j   = (j < 7'd16) ? T_LOW : T_HIGH;
    assign ss1   = rol(a12 + re + rol(t_j, j[4:0]), 5'd7);
    assign ss2   = ss1 ^ a12;
    assign ff_v  = ff_j(ra, rb, rc, j);
    assign gg_v  = gg_j(re, rf, rg, j);
    assign tt1   = ff_v + rd + ss2 + (win[0] ^ win[4]);
    assign tt2   = gg_v + rh + ss1 + win[0];
    assign w_new = p1(win[0] ^ win[7] ^ rol(win[13], 5'd15)) ^ rol(win[3], 5'd7) ^ win[10];

    always_ff @(posedge input_clk) begin
        if (input_rst)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        load     = 1'b0;
        finish   = 1'b0;
        case (state)
            IDLE: begin
                if (input_start) begin
                    load     = 1'b1;
                    state_nx = RUN;
                end
            end
            RUN: begin
                if (j == 7'd63)
                    state_nx = FINAL;
            end
            FINAL: begin
                finish = 1'b1;
                if (input_start) begin
                    load     = 1'b1;
                    state_nx = RUN;
                end else begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge input_clk) begin
        if (input_rst) begin
            output_busy <= 1'b0;
            output_done <= 1'b0;
            output_hash <= '0;
            j           <= '0;
        end else begin
            output_done <= finish;
            if (finish) begin
                output_hash <= {ra, rb, rc, rd, re, rf, rg, rh} ^ v_lat;
                output_busy <= 1'b0;
            end
            // a start in FINAL lands after the fold above, so busy stays high
            if (load) begin
                {ra, rb, rc, rd, re, rf, rg, rh} <= input_V;
                v_lat       <= input_V;
                j           <= '0;
                output_busy <= 1'b1;
                for (int k = 0; k < 16; k++)
                    win[k] <= input_B[511 - 32*k -: 32];
            end else if (state == RUN) begin
                rd <= rc;
                rc <= rol(rb, 5'd9);
                rb <= ra;
                ra <= tt1;
                rh <= rg;
                rg <= rol(rf, 5'd19);
                rf <= re;
                re <= p0(tt2);
                j  <= j + 7'd1;
                for (int k = 0; k < 15; k++)
                    win[k] <= win[k + 1];
                win[15] <= w_new;
            end
        end
    end

endmodule

// File: tb/tb_sm3_compress.sv
// Directed bench for sm3_compress: standard SM3 vectors, back-to-back chaining, ignored
// starts, mid-run reset, input scrambling, and round-boundary probes against a small model.

module tb_sm3_compress;

    localparam logic [255:0] IV = 256'h7380166F_4914B2B9_172442D7_DA8A0600_A96F30BC_163138AA_E38DEE4D_B0FB0E4E;
    localparam logic [511:0] ABC_BLK  = {32'h61626380, 448'h0, 32'h00000018};
    localparam logic [255:0] ABC_HASH = 256'h66C7F0F4_62EEEDD9_D1F2D46B_DC10E4E2_4167C487_5CF2F7A2_297DA02B_8F4BA8E0;
    localparam logic [511:0] BLK1     = {16{32'h61626364}};
    localparam logic [511:0] BLK2     = {32'h80000000, 448'h0, 32'h00000200};
    localparam logic [255:0] TWO_HASH = 256'hDEBE9FF9_2275B8A1_38604889_C18E5A4D_6FDB70E5_387E5765_293DCBA3_9C0C5732;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [255:0] v_in;
    logic [511:0] b_in;
    logic         busy;
    logic         done;
    logic [255:0] hash;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    sm3_compress dut (
        .input_clk   (clk),
        .input_rst   (rst),
        .input_start (start),
        .input_V     (v_in),
        .input_B     (b_in),
        .output_busy (busy),
        .output_done (done),
        .output_hash (hash)
    );

    task automatic check_val(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_chk++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rotl(input logic [31:0] x, input int n);
        return (x << n) | (x >> (32 - n));
    endfunction

    function automatic logic [31:0] p0m(input logic [31:0] x);
        return x ^ rotl(x, 9) ^ rotl(x, 17);
    endfunction

    function automatic logic [31:0] p1m(input logic [31:0] x);
        return x ^ rotl(x, 15) ^ rotl(x, 23);
    endfunction

    // ABCDEFGH after nr rounds, straight from the algorithm with a full W[0..67] array
    function automatic logic [255:0] ref_state(input logic [255:0] v, input logic [511:0] blk, input int nr);
        logic [31:0] w [68];
        logic [31:0] a, b, c, d, e, f, g, h, ss1, ss2, tt1, tt2, tj, fv, gv;
        for (int k = 0; k < 16; k++)
            w[k] = blk[511 - 32*k -: 32];
        for (int k = 16; k < 68; k++)
            w[k] = p1m(w[k-16] ^ w[k-9] ^ rotl(w[k-3], 15)) ^ rotl(w[k-13], 7) ^ w[k-6];
        {a, b, c, d, e, f, g, h} = v;
        for (int jj = 0; jj < nr; jj++) begin
            tj  = (jj < 16) ? 32'h79CC4519 : 32'h7A879D8A;
            ss1 = rotl(rotl(a, 12) + e + rotl(tj, jj % 32), 7);
            ss2 = ss1 ^ rotl(a, 12);
            if (jj < 16) begin
                fv = a ^ b ^ c;
                gv = e ^ f ^ g;
            end else begin
                fv = (a & b) | (a & c) | (b & c);
                gv = (e & f) | (~e & g);
            end
            tt1 = fv + d + ss2 + (w[jj] ^ w[jj + 4]);
            tt2 = gv + h + ss1 + w[jj];
            d = c; c = rotl(b, 9);  b = a; a = tt1;
            h = g; g = rotl(f, 19); f = e; e = p0m(tt2);
        end
        return {a, b, c, d, e, f, g, h};
    endfunction

    task automatic run_abc(input string name, input bit scramble, input bit poke, input bit probe);
        int done_cnt;
        int done_at;
        int busy_cnt;
        v_in  = IV;
        b_in  = ABC_BLK;
        start = 1'b1;
        tick();
        start    = 1'b0;
        done_cnt = 0;
        done_at  = -1;
        busy_cnt = busy ? 1 : 0;
        for (int c = 1; c <= 80; c++) begin
            if (scramble) begin
                for (int k = 0; k < 8; k++)  v_in[32*k +: 32] = $urandom();
                for (int k = 0; k < 16; k++) b_in[32*k +: 32] = $urandom();
            end
            if (poke && (c == 10 || c == 40)) begin
                v_in  = ~IV;
                b_in  = BLK1;
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            tick();
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                done_at = c;
            end
            if (probe && (c == 16 || c == 17 || c == 33 || c == 34))
                check_val($sformatf("%s_state_after_%0d_rounds", name, c),
                          {dut.ra, dut.rb, dut.rc, dut.rd, dut.re, dut.rf, dut.rg, dut.rh},
                          ref_state(IV, ABC_BLK, c));
        end
        start = 1'b0;
        check_val({name, "_done_count"}, 256'(done_cnt), 256'd1);
        check_val({name, "_done_cycle"}, 256'(done_at), 256'd65);
        check_val({name, "_busy_cycles"}, 256'(busy_cnt), 256'd65);
        check_val({name, "_hash"}, hash, ABC_HASH);
    endtask

    initial begin
        int done_cnt;
        int done_at;
        rst   = 1'b1;
        start = 1'b0;
        v_in  = '0;
        b_in  = '0;
        tick();
        tick();
        rst = 1'b0;
        check_val("reset_busy", 256'(busy), 256'd0);
        check_val("reset_done", 256'(done), 256'd0);
        check_val("reset_hash", hash, 256'd0);
        check_val("reset_state", 256'(dut.state), 256'd0);
        check_val("reset_j", 256'(dut.j), 256'd0);

        run_abc("abc", 1'b0, 1'b0, 1'b1);
        run_abc("abc_scramble", 1'b1, 1'b0, 1'b0);
        run_abc("abc_ignored_starts", 1'b0, 1'b1, 1'b0);

        // reset where round 30 would run, with a start in the same cycle
        v_in  = IV;
        b_in  = ABC_BLK;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c <= 30; c++) tick();
        rst   = 1'b1;
        start = 1'b1;
        tick();
        rst   = 1'b0;
        start = 1'b0;
        check_val("midrst_busy", 256'(busy), 256'd0);
        check_val("midrst_done", 256'(done), 256'd0);
        check_val("midrst_hash", hash, 256'd0);
        check_val("midrst_state", 256'(dut.state), 256'd0);
        tick();
        check_val("midrst_still_idle", 256'(busy), 256'd0);
        run_abc("abc_after_reset", 1'b0, 1'b0, 1'b0);

        // two-block chain, second start issued in the FINAL cycle
        v_in  = IV;
        b_in  = BLK1;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c <= 64; c++) tick();
        check_val("chain_final_busy", 256'(busy), 256'd1);
        check_val("chain_final_state", 256'(dut.state), 256'd2);
        v_in  = ref_state(IV, BLK1, 64) ^ IV;
        b_in  = BLK2;
        start = 1'b1;
        tick();
        start = 1'b0;
        check_val("chain_done1", 256'(done), 256'd1);
        check_val("chain_busy_kept", 256'(busy), 256'd1);
        check_val("chain_hash1", hash, ref_state(IV, BLK1, 64) ^ IV);
        done_cnt = 0;
        done_at  = -1;
        for (int c = 66; c <= 140; c++) begin
            tick();
            if (done) begin
                done_cnt++;
                done_at = c;
            end
        end
        check_val("chain_done2_count", 256'(done_cnt), 256'd1);
        check_val("chain_done2_cycle", 256'(done_at), 256'd130);
        check_val("chain_hash2", hash, TWO_HASH);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
